// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the writeback stage.
//   - FSM state encoding for the CSR-read wait machine
//   - exception code constants
//   - MEM->WB bus field offsets and the bus width formula
// Bus layout, MSB->LSB:
//   {rf_we, rf_waddr, rf_wdata, pc, csr_re, csr_we, csr_num,
//    csr_wmask, csr_wvalue, ex, ecode[5:0], ertn}
package wb_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_CSR_WAIT = 2'd1,
        ST_READY    = 2'd2
    } wb_state_e;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_PIL = 6'h01;
    localparam logic [5:0] ECODE_PIS = 6'h02;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam int unsigned PC_W           = 32;
    localparam int unsigned ECODE_W        = 6;
    localparam int unsigned OFF_ERTN       = 0;
    localparam int unsigned OFF_ECODE      = 1;
    localparam int unsigned OFF_EX         = 7;
    localparam int unsigned OFF_CSR_WVALUE = 8;

    function automatic int unsigned off_csr_wmask(input int unsigned data_w);
        return OFF_CSR_WVALUE + data_w;
    endfunction

    function automatic int unsigned off_csr_num(input int unsigned data_w);
        return OFF_CSR_WVALUE + 2 * data_w;
    endfunction

    function automatic int unsigned off_csr_we(input int unsigned data_w,
                                               input int unsigned csrn_w);
        return off_csr_num(data_w) + csrn_w;
    endfunction

    function automatic int unsigned off_csr_re(input int unsigned data_w,
                                               input int unsigned csrn_w);
        return off_csr_we(data_w, csrn_w) + 1;
    endfunction

    function automatic int unsigned off_pc(input int unsigned data_w,
                                           input int unsigned csrn_w);
        return off_csr_re(data_w, csrn_w) + 1;
    endfunction

    function automatic int unsigned off_rf_wdata(input int unsigned data_w,
                                                 input int unsigned csrn_w);
        return off_pc(data_w, csrn_w) + PC_W;
    endfunction

    function automatic int unsigned off_rf_waddr(input int unsigned data_w,
                                                 input int unsigned csrn_w);
        return off_rf_wdata(data_w, csrn_w) + data_w;
    endfunction

    function automatic int unsigned off_rf_we(input int unsigned data_w,
                                              input int unsigned csrn_w,
                                              input int unsigned raddr_w);
        return off_rf_waddr(data_w, csrn_w) + raddr_w;
    endfunction

    function automatic int unsigned bus_w(input int unsigned raddr_w,
                                          input int unsigned data_w,
                                          input int unsigned csrn_w);
        return 1 + raddr_w + data_w + 32 + 1 + 1 + csrn_w + 2 * data_w + 1 + 6 + 1;
    endfunction

endpackage

// File: rtl/wb_csr_wait.sv
// wb_csr_wait: retire-readiness FSM for the writeback stage.
// Holds the EMPTY/CSR_WAIT/READY machine, the CSR latency counter and the
// register that captures csr_rvalue on entry to READY.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   load         - an instruction is latched into WB this cycle
//   load_csr     - that instruction reads a CSR and carries no exception
//   retire       - the current instruction leaves WB this cycle
//   csr_rvalue   - read data from the CSR file
//   ready_go     - current instruction may retire
//   csr_data     - CSR read data to write back
module wb_csr_wait
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CSR_RD_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_csr,
    input  logic              retire,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              ready_go,
    output logic [DATA_W-1:0] csr_data
);

    localparam logic [1:0] LAST_CNT = (CSR_RD_LAT > 0) ? 2'(CSR_RD_LAT - 1) : 2'd0;

    wb_state_e         state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] csr_cap;
    logic              do_capture;
    logic              load_wait;

    // With zero latency the read data is used combinationally, so no wait.
    assign load_wait = load_csr && (CSR_RD_LAT > 0);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        do_capture = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (load) begin
                    state_nxt = load_wait ? ST_CSR_WAIT : ST_READY;
                    cnt_nxt   = '0;
                end
            end
            ST_CSR_WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt  = ST_READY;
                    do_capture = 1'b1;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            ST_READY: begin
                // A load while READY only happens together with retire.
                if (retire) begin
                    if (load) begin
                        state_nxt = load_wait ? ST_CSR_WAIT : ST_READY;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_EMPTY;
            cnt     <= '0;
            csr_cap <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (do_capture) begin
                csr_cap <= csr_rvalue;
            end
        end
    end

    assign ready_go = (state == ST_READY);

    always_comb begin
        csr_data = (CSR_RD_LAT == 0) ? csr_rvalue : csr_cap;
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline stage after MEM.
// Latches one instruction from MEM, waits for multi-cycle CSR reads, then
// retires it: register-file write, CSR write, exception/ertn commit with
// pipeline flush, ID forwarding and debug trace.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   mem_to_wb_valid/_bus           - instruction offered by MEM
//   wb_allowin                     - WB accepts a new instruction
//   wb_to_id_bus                   - {we, data_ok, waddr, wdata} bypass to ID
//   csr_re/csr_num/csr_rvalue      - CSR read port
//   csr_we/csr_wmask/csr_wvalue    - CSR write port
//   wb_ex/wb_ecode/wb_ex_pc        - exception commit
//   wb_ertn, wb_flush              - ertn commit, kill IF..MEM
//   debug_wb_*                     - retire trace
//   wb_retire_cnt                  - retire counter, only with WB_PERF_CNT_EN
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter  int unsigned DATA_W     = 32,
    parameter  int unsigned RADDR_W    = 5,
    parameter  int unsigned CSRN_W     = 14,
    parameter  int unsigned CSR_RD_LAT = 0,
    localparam int unsigned BUS_W      = bus_w(RADDR_W, DATA_W, CSRN_W)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_to_wb_valid,
    input  logic [BUS_W-1:0]            mem_to_wb_bus,
    output logic                        wb_allowin,
    output logic [2+RADDR_W+DATA_W-1:0] wb_to_id_bus,
    output logic                        csr_re,
    output logic [CSRN_W-1:0]           csr_num,
    input  logic [DATA_W-1:0]           csr_rvalue,
    output logic                        csr_we,
    output logic [DATA_W-1:0]           csr_wmask,
    output logic [DATA_W-1:0]           csr_wvalue,
    output logic                        wb_ex,
    output logic [5:0]                  wb_ecode,
    output logic [31:0]                 wb_ex_pc,
    output logic                        wb_ertn,
    output logic                        wb_flush,
    output logic [31:0]                 debug_wb_pc,
    output logic [3:0]                  debug_wb_rf_we,
    output logic [RADDR_W-1:0]          debug_wb_rf_wnum,
`ifdef WB_PERF_CNT_EN
    output logic [63:0]                 wb_retire_cnt,
`endif
    output logic [DATA_W-1:0]           debug_wb_rf_wdata
);

    localparam int unsigned O_CSR_WMASK = off_csr_wmask(DATA_W);
    localparam int unsigned O_CSR_NUM   = off_csr_num(DATA_W);
    localparam int unsigned O_CSR_WE    = off_csr_we(DATA_W, CSRN_W);
    localparam int unsigned O_CSR_RE    = off_csr_re(DATA_W, CSRN_W);
    localparam int unsigned O_PC        = off_pc(DATA_W, CSRN_W);
    localparam int unsigned O_RF_WDATA  = off_rf_wdata(DATA_W, CSRN_W);
    localparam int unsigned O_RF_WADDR  = off_rf_waddr(DATA_W, CSRN_W);
    localparam int unsigned O_RF_WE     = off_rf_we(DATA_W, CSRN_W, RADDR_W);

    logic               wb_valid;
    logic [BUS_W-1:0]   payload;
    logic               wb_ready_go;
    logic               retire;
    logic               latch;
    logic               rf_commit;
    logic [DATA_W-1:0]  csr_data;
    logic [DATA_W-1:0]  final_wdata;

    logic               p_rf_we;
    logic [RADDR_W-1:0] p_rf_waddr;
    logic [DATA_W-1:0]  p_rf_wdata;
    logic [31:0]        p_pc;
    logic               p_csr_re;
    logic               p_csr_we;
    logic               p_ex;
    logic [5:0]         p_ecode;
    logic               p_ertn;

    assign p_rf_we    = payload[O_RF_WE];
    assign p_rf_waddr = payload[O_RF_WADDR +: RADDR_W];
    assign p_rf_wdata = payload[O_RF_WDATA +: DATA_W];
    assign p_pc       = payload[O_PC +: PC_W];
    assign p_csr_re   = payload[O_CSR_RE];
    assign p_csr_we   = payload[O_CSR_WE];
    assign p_ex       = payload[OFF_EX];
    assign p_ecode    = payload[OFF_ECODE +: ECODE_W];
    assign p_ertn     = payload[OFF_ERTN];

    assign wb_allowin = ~wb_valid | wb_ready_go;
    assign retire     = wb_valid & wb_ready_go;
    assign wb_flush   = retire & (p_ex | p_ertn);
    // A flushing retire kills whatever MEM offers in the same cycle.
    assign latch      = mem_to_wb_valid & wb_allowin & ~wb_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            payload  <= '0;
        end else begin
            if (wb_allowin) begin
                wb_valid <= mem_to_wb_valid & ~wb_flush;
            end
            if (latch) begin
                payload <= mem_to_wb_bus;
            end
        end
    end

    wb_csr_wait #(
        .DATA_W     (DATA_W),
        .CSR_RD_LAT (CSR_RD_LAT)
    ) u_csr_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (latch),
        .load_csr   (mem_to_wb_bus[O_CSR_RE] & ~mem_to_wb_bus[OFF_EX]),
        .retire     (retire),
        .csr_rvalue (csr_rvalue),
        .ready_go   (wb_ready_go),
        .csr_data   (csr_data)
    );

    assign csr_re      = wb_valid & p_csr_re & ~p_ex;
    assign csr_num     = payload[O_CSR_NUM +: CSRN_W];
    assign csr_wmask   = payload[O_CSR_WMASK +: DATA_W];
    assign csr_wvalue  = payload[OFF_CSR_WVALUE +: DATA_W];
    assign csr_we      = retire & p_csr_we & ~p_ex;

    assign final_wdata = csr_re ? csr_data : p_rf_wdata;
    assign rf_commit   = retire & p_rf_we & ~p_ex;

    assign wb_ex       = retire & p_ex;
    assign wb_ecode    = wb_ex ? p_ecode : '0;
    assign wb_ex_pc    = wb_ex ? p_pc : '0;
    assign wb_ertn     = retire & p_ertn & ~p_ex;

    assign wb_to_id_bus = {wb_valid & p_rf_we & ~p_ex, wb_ready_go, p_rf_waddr, final_wdata};

    assign debug_wb_pc       = p_pc;
    assign debug_wb_rf_we    = {4{rf_commit}};
    assign debug_wb_rf_wnum  = p_rf_waddr;
    assign debug_wb_rf_wdata = final_wdata;

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_retire_cnt <= '0;
        end else if (retire & ~p_ex) begin
            wb_retire_cnt <= wb_retire_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage (CSR_RD_LAT=2).
// A cycle-level occupancy model (valid flag plus remaining-wait countdown)
// predicts every output; directed steps add explicit constant checks.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ex;
        logic [5:0]  ecode;
        logic        ertn;
    } ins_t;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         mem_to_wb_valid;
    logic [157:0] mem_to_wb_bus;
    logic         wb_allowin;
    logic [38:0]  wb_to_id_bus;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         wb_ex;
    logic [5:0]   wb_ecode;
    logic [31:0]  wb_ex_pc;
    logic         wb_ertn;
    logic         wb_flush;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;
`ifdef WB_PERF_CNT_EN
    logic [63:0]  wb_retire_cnt;
`endif

    wb_stage #(
        .DATA_W     (32),
        .RADDR_W    (5),
        .CSRN_W     (14),
        .CSR_RD_LAT (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_allowin        (wb_allowin),
        .wb_to_id_bus      (wb_to_id_bus),
        .csr_re            (csr_re),
        .csr_num           (csr_num),
        .csr_rvalue        (csr_rvalue),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .wb_ex             (wb_ex),
        .wb_ecode          (wb_ecode),
        .wb_ex_pc          (wb_ex_pc),
        .wb_ertn           (wb_ertn),
        .wb_flush          (wb_flush),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
`ifdef WB_PERF_CNT_EN
        .wb_retire_cnt     (wb_retire_cnt),
`endif
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what is held in WB and how many cycles it still waits.
    logic        mv;
    ins_t        mi;
    int unsigned mwait;
    logic [31:0] mcsr;
`ifdef WB_PERF_CNT_EN
    logic [63:0] mcnt;
`endif

    logic        cur_v;
    logic        cur_rst;
    ins_t        cur_in;
    logic [31:0] cur_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic        rdy, ret, cre;
        logic [31:0] fin;
        rdy = mv && (mwait == 0);
        ret = rdy;
        cre = mv && mi.csr_re && !mi.ex;
        fin = cre ? mcsr : mi.wdata;
        chk("allowin",    wb_allowin, !mv || rdy);
        chk("csr_re",     csr_re, cre);
        chk("csr_num",    csr_num, mi.num);
        chk("csr_we",     csr_we, ret && mi.csr_we && !mi.ex);
        chk("csr_wmask",  csr_wmask, mi.wmask);
        chk("csr_wvalue", csr_wvalue, mi.wvalue);
        chk("wb_ex",      wb_ex, ret && mi.ex);
        chk("wb_ecode",   wb_ecode, (ret && mi.ex) ? mi.ecode : 6'd0);
        chk("wb_ex_pc",   wb_ex_pc, (ret && mi.ex) ? mi.pc : 32'd0);
        chk("wb_ertn",    wb_ertn, ret && mi.ertn && !mi.ex);
        chk("wb_flush",   wb_flush, ret && (mi.ex || mi.ertn));
        chk("id_bus",     wb_to_id_bus, {mv && mi.rf_we && !mi.ex, rdy, mi.waddr, fin});
        chk("dbg_pc",     debug_wb_pc, mi.pc);
        chk("dbg_rf_we",  debug_wb_rf_we, {4{ret && mi.rf_we && !mi.ex}});
        chk("dbg_wnum",   debug_wb_rf_wnum, mi.waddr);
        chk("dbg_wdata",  debug_wb_rf_wdata, fin);
`ifdef WB_PERF_CNT_EN
        chk("retire_cnt", wb_retire_cnt, mcnt);
`endif
    endtask

    // Apply inputs just after a rising edge, then check at the falling edge.
    task automatic drive(input logic v, input ins_t in, input logic [31:0] rv, input logic rst);
        cur_v = v; cur_in = in; cur_rv = rv; cur_rst = rst;
        mem_to_wb_valid = v;
        mem_to_wb_bus   = in;
        csr_rvalue      = rv;
        reset           = rst;
        @(negedge clk);
        check_model();
    endtask

    // Advance the model across the rising edge.
    task automatic tick();
        logic rdy, fl;
        rdy = mv && (mwait == 0);
        fl  = rdy && (mi.ex || mi.ertn);
        if (cur_rst) begin
            mv = 1'b0; mi = '0; mwait = 0; mcsr = '0;
`ifdef WB_PERF_CNT_EN
            mcnt = '0;
`endif
        end else if (!mv || rdy) begin
`ifdef WB_PERF_CNT_EN
            if (rdy && !mi.ex) mcnt = mcnt + 64'd1;
`endif
            if (cur_v && !fl) begin
                mi    = cur_in;
                mv    = 1'b1;
                mwait = (cur_in.csr_re && !cur_in.ex) ? LAT : 0;
            end else begin
                mv = 1'b0;
            end
        end else begin
            if (mwait == 1) mcsr = cur_rv;
            mwait = mwait - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input ins_t in);
        drive(v, in, $urandom, 1'b0);
        tick();
    endtask

    function automatic ins_t alu(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        ins_t t;
        t = '0;
        t.rf_we = 1'b1; t.waddr = wa; t.wdata = wd; t.pc = pc;
        return t;
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        t.rf_we  = 1'($urandom);
        t.waddr  = 5'($urandom);
        t.wdata  = $urandom;
        t.pc     = $urandom;
        t.csr_re = ($urandom_range(0, 2) == 0);
        t.csr_we = 1'($urandom);
        t.num    = 14'($urandom);
        t.wmask  = $urandom;
        t.wvalue = $urandom;
        t.ex     = ($urandom_range(0, 9) == 0);
        t.ecode  = 6'($urandom);
        t.ertn   = ($urandom_range(0, 9) == 0);
        return t;
    endfunction

    ins_t a, b, c, z;

    initial begin
        z = '0;
        mv = 1'b0; mi = '0; mwait = 0; mcsr = '0;
`ifdef WB_PERF_CNT_EN
        mcnt = '0;
`endif
        reset = 1'b1; mem_to_wb_valid = 1'b0; mem_to_wb_bus = '0; csr_rvalue = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state.
        drive(1'b0, z, 32'h0, 1'b1);
        chk("rst_allowin", wb_allowin, 1'b1);
        chk("rst_rf_we",   debug_wb_rf_we, 4'h0);
        chk("rst_id_bus",  wb_to_id_bus, 39'h0);
        tick();

        // Back-to-back ALU writes.
        a = alu(5'd1, 32'h11, 32'h1C000000);
        b = alu(5'd2, 32'h22, 32'h1C000004);
        drive(1'b1, a, 32'h0, 1'b0);
        chk("alu_allowin0", wb_allowin, 1'b1);
        tick();
        drive(1'b1, b, 32'h0, 1'b0);
        chk("alu1_we",    debug_wb_rf_we, 4'hF);
        chk("alu1_wnum",  debug_wb_rf_wnum, 5'd1);
        chk("alu1_wdata", debug_wb_rf_wdata, 32'h11);
        chk("alu1_pc",    debug_wb_pc, 32'h1C000000);
        chk("alu1_allow", wb_allowin, 1'b1);
        tick();
        drive(1'b0, z, 32'h0, 1'b0);
        chk("alu2_we",    debug_wb_rf_we, 4'hF);
        chk("alu2_wnum",  debug_wb_rf_wnum, 5'd2);
        chk("alu2_wdata", debug_wb_rf_wdata, 32'h22);
        tick();

        // CSR read with 2-cycle latency; the following instruction is held.
        a = alu(5'd3, 32'h0, 32'h1C000010);
        a.csr_re = 1'b1; a.num = 14'h005;
        b = alu(5'd4, 32'h44, 32'h1C000014);
        drive(1'b1, a, $urandom, 1'b0);
        tick();
        drive(1'b1, b, $urandom, 1'b0);
        chk("csr_w1_allow", wb_allowin, 1'b0);
        chk("csr_w1_ok",    wb_to_id_bus[37], 1'b0);
        chk("csr_w1_re",    csr_re, 1'b1);
        chk("csr_w1_num",   csr_num, 14'h005);
        tick();
        drive(1'b1, b, 32'hDEADBEEF, 1'b0);
        chk("csr_w2_allow", wb_allowin, 1'b0);
        chk("csr_w2_rfwe",  debug_wb_rf_we, 4'h0);
        tick();
        drive(1'b1, b, $urandom, 1'b0);
        chk("csr_ret_we",    debug_wb_rf_we, 4'hF);
        chk("csr_ret_wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
        chk("csr_ret_ok",    wb_to_id_bus[37], 1'b1);
        tick();
        drive(1'b0, z, 32'h0, 1'b0);
        chk("held_pc",    debug_wb_pc, 32'h1C000014);
        chk("held_wdata", debug_wb_rf_wdata, 32'h44);
        tick();

        // Exception on a csrwr: flush, no side effects, MEM offer dropped.
        a = alu(5'd5, 32'h55, 32'h1C000100);
        a.csr_we = 1'b1; a.ex = 1'b1; a.ecode = ECODE_SYS;
        b = alu(5'd6, 32'h66, 32'h1C000104);
        cyc(1'b1, a);
        drive(1'b1, b, $urandom, 1'b0);
        chk("ex_pulse", wb_ex, 1'b1);
        chk("ex_ecode", wb_ecode, 6'h0B);
        chk("ex_pc",    wb_ex_pc, 32'h1C000100);
        chk("ex_flush", wb_flush, 1'b1);
        chk("ex_csrwe", csr_we, 1'b0);
        chk("ex_rfwe",  debug_wb_rf_we, 4'h0);
        tick();
        drive(1'b0, z, 32'h0, 1'b0);
        chk("ex_drop_we",    wb_to_id_bus[38], 1'b0);
        chk("ex_drop_allow", wb_allowin, 1'b1);
        chk("ex_drop_ex",    wb_ex, 1'b0);
        tick();

        // ertn.
        a = '0; a.ertn = 1'b1; a.pc = 32'h1C000200;
        cyc(1'b1, a);
        drive(1'b0, z, 32'h0, 1'b0);
        chk("ertn_pulse", wb_ertn, 1'b1);
        chk("ertn_flush", wb_flush, 1'b1);
        chk("ertn_rfwe",  debug_wb_rf_we, 4'h0);
        tick();
        drive(1'b0, z, 32'h0, 1'b0);
        chk("ertn_single", wb_ertn, 1'b0);
        tick();

        // Reset during CSR_WAIT.
        a = alu(5'd7, 32'h77, 32'h1C000300);
        a.csr_re = 1'b1; a.csr_we = 1'b1;
        cyc(1'b1, a);
        drive(1'b0, z, $urandom, 1'b1);
        chk("rstw_csrwe", csr_we, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, z, $urandom, 1'b0);
            chk("rstw_allow", wb_allowin, 1'b1);
            chk("rstw_csrwe", csr_we, 1'b0);
            chk("rstw_rfwe",  debug_wb_rf_we, 4'h0);
            tick();
        end

`ifdef WB_PERF_CNT_EN
        drive(1'b0, z, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) cyc(1'b1, alu(5'(i + 1), 32'(i), 32'h1C000400 + 32'(4 * i)));
        c = alu(5'd9, 32'h99, 32'h1C000500);
        c.ex = 1'b1; c.ecode = ECODE_BRK;
        cyc(1'b1, c);
        cyc(1'b0, z);
        drive(1'b0, z, 32'h0, 1'b0);
        chk("perf_cnt4", wb_retire_cnt, 64'd4);
        tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            c = rand_ins();
            drive(($urandom_range(0, 3) != 0), c, $urandom, ($urandom_range(0, 63) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
